// File: rtl/uart_rx_frame.sv
// uart_rx_frame -- parametrised UART receiver.
//
// Synchronises the serial line with two flops. Each bit is timed with a
// counter and decided by a 3-sample majority vote around the bit centre.
// Supports 5..9 data bits, none/odd/even parity, 1 or 2 stop bits and
// LSB- or MSB-first order. Reports parity, framing and break conditions,
// and emits one single-cycle valid pulse per received frame.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   enable         synchronous clear when low (synchroniser keeps running)
//   uart_rx        asynchronous serial line, idle high
//   data_out       received data word, held until the next frame
//   data_out_valid single-cycle pulse: data_out and the error flags are valid
//   parity_err     parity mismatch in the last frame
//   frame_err      a stop bit was sampled low in the last frame
//   break_det      data, parity and stop bits all sampled low
//   uart_rx_busy   high from start-bit detection until return to idle
module uart_rx_frame #(
  parameter int CLK_FRQ_MHZ = 24,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int LSB_FIRST   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_out_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 uart_rx_busy
);

  localparam int BIT_CLKS = (CLK_FRQ_MHZ * 1000000) / BAUD_RATE;
  localparam int HALF     = BIT_CLKS / 2;
  localparam int CNT_W    = $clog2(BIT_CLKS);

  localparam logic [CNT_W-1:0] CNT_SAMP_A = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_SAMP_B = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(HALF + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BIT_CLKS - 1);
  localparam logic [3:0]       LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic             LAST_STOP  = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
  localparam logic [2:0] S_PARITY   = 3'd3;
  localparam logic [2:0] S_STOP     = 3'd4;
  localparam logic [2:0] S_BRK_WAIT = 3'd5;

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 pe;
  logic                 fe;
  logic                 samp_a;
  logic                 samp_b;

  logic maj;
  logic wrap;
  logic decide;
  logic par_bad;
  logic stop_fe;
  logic frame_brk;

  // NOTE: the synchroniser flops reset to 1 (idle line) so that leaving
  // reset is never mistaken for a start bit; enable does not touch them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], uart_rx};
  end

  assign rx_s   = sync_q[1];
  assign wrap   = (cnt == CNT_LAST);
  assign decide = (cnt == CNT_DECIDE);

  // Third sample is rx_s itself at the decision point.
  assign maj = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

  // Odd parity wants data^parity == 1, even wants 0; order of bits is irrelevant.
  assign par_bad   = (PARITY == 1) ? ~(^shreg ^ maj) : (^shreg ^ maj);
  assign stop_fe   = fe | ~maj;
  assign frame_brk = stop_fe & (shreg == '0) & ((PARITY == 0) | ~par_bit);

  // NOTE: all state here uses non-blocking assignments so every flop sees
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      stop_idx       <= 1'b0;
      shreg          <= '0;
      par_bit        <= 1'b0;
      pe             <= 1'b0;
      fe             <= 1'b0;
      samp_a         <= 1'b1;
      samp_b         <= 1'b1;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      parity_err     <= 1'b0;
      frame_err      <= 1'b0;
      break_det      <= 1'b0;
      uart_rx_busy   <= 1'b0;
    end else if (!enable) begin
      state          <= S_IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      stop_idx       <= 1'b0;
      shreg          <= '0;
      par_bit        <= 1'b0;
      pe             <= 1'b0;
      fe             <= 1'b0;
      samp_a         <= 1'b1;
      samp_b         <= 1'b1;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      parity_err     <= 1'b0;
      frame_err      <= 1'b0;
      break_det      <= 1'b0;
      uart_rx_busy   <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;

      // The bit timer only runs while a frame is being timed; exits below
      // park it at zero so the next start bit begins a fresh bit period.
      if (state != S_IDLE && state != S_BRK_WAIT)
        cnt <= wrap ? '0 : cnt + 1'b1;

      if (cnt == CNT_SAMP_A) samp_a <= rx_s;
      if (cnt == CNT_SAMP_B) samp_b <= rx_s;

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state        <= S_START;
            cnt          <= '0;
            uart_rx_busy <= 1'b1;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            pe           <= 1'b0;
            fe           <= 1'b0;
          end
        end

        S_START: begin
          if (decide && maj) begin
            // Low pulse too short to be a start bit.
            state        <= S_IDLE;
            cnt          <= '0;
            uart_rx_busy <= 1'b0;
          end else if (wrap) begin
            state   <= S_DATA;
            bit_idx <= '0;
          end
        end

        S_DATA: begin
          if (decide) begin
            if (LSB_FIRST != 0) shreg <= {maj, shreg[DATA_BITS-1:1]};
            else                shreg <= {shreg[DATA_BITS-2:0], maj};
          end
          if (wrap) begin
            if (bit_idx == LAST_DATA) state <= (PARITY != 0) ? S_PARITY : S_STOP;
            else                      bit_idx <= bit_idx + 4'd1;
          end
        end

        S_PARITY: begin
          if (decide) begin
            par_bit <= maj;
            pe      <= par_bad;
          end
          if (wrap) state <= S_STOP;
        end

        S_STOP: begin
          if (decide) begin
            fe <= stop_fe;
            if (stop_idx == LAST_STOP) begin
              // Leave at mid-stop so the next start edge is caught even
              // when the sender runs up to half a bit fast.
              data_out       <= shreg;
              data_out_valid <= 1'b1;
              parity_err     <= pe;
              frame_err      <= stop_fe;
              break_det      <= frame_brk;
              uart_rx_busy   <= frame_brk;
              state          <= frame_brk ? S_BRK_WAIT : S_IDLE;
              cnt            <= '0;
            end
          end else if (wrap) begin
            stop_idx <= stop_idx + 1'b1;
          end
        end

        S_BRK_WAIT: begin
          if (rx_s) begin
            state        <= S_IDLE;
            uart_rx_busy <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame. Three receivers with different
// frame formats share clock, reset and enable; each has its own serial line.
//   dut 0: 8 data, no parity, 1 stop, LSB first
//   dut 1: 7 data, even parity, 2 stop, LSB first
//   dut 2: 9 data, odd parity, 1 stop, MSB first
// The bit period is shortened (16 clocks) to keep the run short.
module tb_uart_rx_frame;

  localparam int CLK_MHZ = 1;
  localparam int BAUD    = 62500;
  localparam int BIT     = (CLK_MHZ * 1000000) / BAUD;
  localparam int HALF    = BIT / 2;

  typedef struct packed {
    logic [8:0]  data;
    logic        pe;
    logic        fe;
    logic        brk;
    logic [31:0] cyc;
  } rec_t;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [2:0] rx_line;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic [8:0] data_c;
  logic [2:0] valid_w, pe_w, fe_w, brk_w, busy_w;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   obs_cnt [3];
  int   busy_cnt [3];
  rec_t last_rec [3];

  uart_rx_frame #(.CLK_FRQ_MHZ(CLK_MHZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1), .LSB_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .uart_rx(rx_line[0]),
    .data_out(data_a), .data_out_valid(valid_w[0]), .parity_err(pe_w[0]),
    .frame_err(fe_w[0]), .break_det(brk_w[0]), .uart_rx_busy(busy_w[0]));

  uart_rx_frame #(.CLK_FRQ_MHZ(CLK_MHZ), .BAUD_RATE(BAUD), .DATA_BITS(7),
                  .PARITY(2), .STOP_BITS(2), .LSB_FIRST(1)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .uart_rx(rx_line[1]),
    .data_out(data_b), .data_out_valid(valid_w[1]), .parity_err(pe_w[1]),
    .frame_err(fe_w[1]), .break_det(brk_w[1]), .uart_rx_busy(busy_w[1]));

  uart_rx_frame #(.CLK_FRQ_MHZ(CLK_MHZ), .BAUD_RATE(BAUD), .DATA_BITS(9),
                  .PARITY(1), .STOP_BITS(1), .LSB_FIRST(0)) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .uart_rx(rx_line[2]),
    .data_out(data_c), .data_out_valid(valid_w[2]), .parity_err(pe_w[2]),
    .frame_err(fe_w[2]), .break_det(brk_w[2]), .uart_rx_busy(busy_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int db_of(input int s);
    return (s == 0) ? 8 : (s == 1) ? 7 : 9;
  endfunction
  function automatic int par_of(input int s);
    return (s == 0) ? 0 : (s == 1) ? 2 : 1;
  endfunction
  function automatic int sb_of(input int s);
    return (s == 1) ? 2 : 1;
  endfunction
  function automatic bit lsb_of(input int s);
    return (s != 2);
  endfunction

  function automatic logic [8:0] get_data(input int s);
    case (s)
      0:       return {1'b0, data_a};
      1:       return {2'b00, data_b};
      default: return data_c;
    endcase
  endfunction

  // Monitor: record every valid pulse and count busy cycles per receiver.
  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (valid_w[s]) begin
        obs_cnt[s]       <= obs_cnt[s] + 1;
        last_rec[s].data <= get_data(s);
        last_rec[s].pe   <= pe_w[s];
        last_rec[s].fe   <= fe_w[s];
        last_rec[s].brk  <= brk_w[s];
        last_rec[s].cyc  <= cyc;
      end
      if (busy_w[s]) busy_cnt[s] <= busy_cnt[s] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: what a frame with these line bits must report.
  function automatic rec_t model(input int s, input logic [8:0] data,
                                 input logic par_bit, input logic [1:0] stops);
    rec_t r;
    int   ones;
    r      = '0;
    r.data = data;
    ones   = $countones(data) + int'(par_bit);
    if (par_of(s) == 1)      r.pe = (ones % 2) == 0;
    else if (par_of(s) == 2) r.pe = (ones % 2) == 1;
    for (int i = 0; i < sb_of(s); i++)
      if (!stops[i]) r.fe = 1'b1;
    r.brk = r.fe && (data == 0) && (par_of(s) == 0 || par_bit == 1'b0);
    return r;
  endfunction

  task automatic idle_bits(input int s, input int nb);
    repeat (nb * BIT) begin
      @(negedge clk);
      rx_line[s] = 1'b1;
    end
  endtask

  // Drive one frame, then check the single pulse it must produce,
  // including its exact cycle relative to the falling start edge.
  task automatic send_frame(input int s, input logic [8:0] data, input bit bad_par,
                            input logic [1:0] stops, input int glitch_bit,
                            input int gap_bits, input string tag);
    logic bits [16];
    int   n, ones, base, t_fall, lat, db;
    logic par_bit;
    rec_t exp;
    db   = db_of(s);
    ones = $countones(data);
    par_bit = (par_of(s) == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
    if (bad_par) par_bit = ~par_bit;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < db; i++) begin
      bits[n] = lsb_of(s) ? data[i] : data[db-1-i];
      n++;
    end
    if (par_of(s) != 0) begin bits[n] = par_bit; n++; end
    for (int i = 0; i < sb_of(s); i++) begin bits[n] = stops[i]; n++; end
    exp    = model(s, data, par_bit, stops);
    base   = obs_cnt[s];
    t_fall = 0;
    for (int b = 0; b < n; b++) begin
      for (int j = 0; j < BIT; j++) begin
        @(negedge clk);
        if (b == 0 && j == 0) t_fall = cyc;
        rx_line[s] = bits[b] ^ (b == glitch_bit && j == HALF + 1);
      end
    end
    lat = 4 + (n - 1) * BIT + HALF;
    check({tag, " pulses"}, obs_cnt[s] - base, 1);
    check({tag, " data"},   last_rec[s].data, exp.data);
    check({tag, " parity"}, last_rec[s].pe,   exp.pe);
    check({tag, " frame"},  last_rec[s].fe,   exp.fe);
    check({tag, " break"},  last_rec[s].brk,  exp.brk);
    check({tag, " cycle"},  last_rec[s].cyc,  t_fall + 1 + lat);
    if (gap_bits > 0) begin
      idle_bits(s, gap_bits);
      check({tag, " busy"}, busy_w[s], 1'b0);
    end
  endtask

  // Start an 8N1 frame on receiver 0 and kill it during data bit 4.
  task automatic abort_frame(input logic [7:0] data, input bit use_rst, input string tag);
    logic bits [10];
    int   base;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    bits[9] = 1'b1;
    base = obs_cnt[0];
    for (int b = 0; b < 10; b++) begin
      for (int j = 0; j < BIT; j++) begin
        @(negedge clk);
        rx_line[0] = bits[b];
        if (b == 5 && j == 2) begin
          if (use_rst) rst = 1'b0;
          else         enable = 1'b0;
        end
      end
    end
    idle_bits(0, 1);
    check({tag, " data"},  data_a,     8'h00);
    check({tag, " valid"}, valid_w[0], 1'b0);
    check({tag, " flags"}, {pe_w[0], fe_w[0], brk_w[0]}, 3'b000);
    check({tag, " busy"},  busy_w[0],  1'b0);
    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b1;
    idle_bits(0, 1);
    check({tag, " pulses"}, obs_cnt[0] - base, 0);
  endtask

  initial begin
    int          base, bb, t_fall, db, gap, glitch;
    logic [8:0]  data;
    logic [1:0]  stops;
    bit          bad_par, bad_stop;

    rst     = 1'b0;
    enable  = 1'b1;
    rx_line = 3'b111;
    repeat (3) @(negedge clk);
    check("reset data",  data_a, 8'h00);
    check("reset valid", valid_w, 3'b000);
    check("reset flags", {pe_w[0], fe_w[0], brk_w[0]}, 3'b000);
    check("reset busy",  busy_w, 3'b000);
    rst = 1'b1;
    idle_bits(0, 2);

    // Basic 8N1 frame with exact latency.
    send_frame(0, 9'h0A5, 1'b0, 2'b11, -1, 2, "8n1 a5");

    // Short low pulse: false start.
    base = obs_cnt[0];
    bb   = busy_cnt[0];
    repeat (6) begin
      @(negedge clk);
      rx_line[0] = 1'b0;
    end
    idle_bits(0, 2);
    check("false start pulses", obs_cnt[0] - base, 0);
    check("false start busy cycles", busy_cnt[0] - bb, HALF + 2);

    // 7E2: good and bad parity.
    send_frame(1, 9'h041, 1'b0, 2'b11, -1, 1, "7e good");
    send_frame(1, 9'h041, 1'b1, 2'b11, -1, 1, "7e bad");

    // Low stop bit, then a clean frame clears the flag.
    send_frame(0, 9'h03C, 1'b0, 2'b10, -1, 3, "stop low");
    send_frame(0, 9'h055, 1'b0, 2'b11, -1, 1, "after fe");

    // Long break.
    base   = obs_cnt[0];
    t_fall = 0;
    for (int j = 0; j < 40 * BIT; j++) begin
      @(negedge clk);
      if (j == 0) t_fall = cyc;
      rx_line[0] = 1'b0;
    end
    check("break pulses", obs_cnt[0] - base, 1);
    check("break data",   last_rec[0].data, 9'h000);
    check("break fe",     last_rec[0].fe, 1'b1);
    check("break det",    last_rec[0].brk, 1'b1);
    check("break cycle",  last_rec[0].cyc, t_fall + 5 + 9 * BIT + HALF);
    check("break busy held", busy_w[0], 1'b1);
    idle_bits(0, 3);
    check("break busy release", busy_w[0], 1'b0);
    check("break single pulse", obs_cnt[0] - base, 1);
    send_frame(0, 9'h012, 1'b0, 2'b11, -1, 1, "after break");

    // Glitch on data bit 3 at the centre sample is outvoted.
    send_frame(0, 9'h000, 1'b0, 2'b11, 4, 1, "glitch");

    // Abandoned frames, then recovery.
    send_frame(0, 9'h0C3, 1'b0, 2'b11, -1, 1, "pre abort");
    abort_frame(8'h5A, 1'b0, "enable abort");
    send_frame(0, 9'h096, 1'b0, 2'b11, -1, 1, "after enable");
    abort_frame(8'h5A, 1'b1, "reset abort");
    send_frame(0, 9'h096, 1'b0, 2'b11, -1, 1, "after reset");

    // Back-to-back frames with two stop bits.
    send_frame(1, 9'h07F, 1'b0, 2'b11, -1, 0, "b2b first");
    send_frame(1, 9'h07F, 1'b0, 2'b11, -1, 1, "b2b second");

    // Randomised frames on all three formats.
    for (int s = 0; s < 3; s++) begin
      db = db_of(s);
      for (int k = 0; k < 8; k++) begin
        data = 9'($urandom) & ((9'h1 << db) - 9'h1);
        if ($urandom_range(0, 7) == 0) data = '0;
        bad_par = (par_of(s) != 0) && ($urandom_range(0, 3) == 0);
        stops[0] = ($urandom_range(0, 4) != 0);
        stops[1] = ($urandom_range(0, 4) != 0);
        bad_stop = 1'b0;
        for (int i = 0; i < sb_of(s); i++)
          if (!stops[i]) bad_stop = 1'b1;
        glitch = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, db)) : -1;
        gap    = bad_stop ? 3 : int'($urandom_range(0, 2));
        send_frame(s, data, bad_par, stops, glitch, gap, $sformatf("rand%0d.%0d", s, k));
      end
      idle_bits(s, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. Adds configurable data width, parity and stop bits, a 2-FF input synchroniser, false-start rejection, 3-sample majority voting, and parity/framing/break error reporting. Sits between the board UART pin and the byte-consumer logic. Emits one single-cycle valid pulse per received frame.

Parameters:
CLK_FRQ_MHZ, 24, system clock frequency in MHz.
BAUD_RATE, 9600, line bit rate. BIT_CLKS = integer(CLK_FRQ_MHZ*1e6/BAUD_RATE); HALF = BIT_CLKS/2 (truncated).
DATA_BITS, 8, data bits per frame, legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
LSB_FIRST, 1, 1 = first received data bit is data_out[0]; 0 = first bit is data_out[DATA_BITS-1].

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  asynchronous, active-low reset.
enable  in  1  synchronous clear when low.
uart_rx  in  1  asynchronous serial line, idle high.
data_out  out  DATA_BITS  received data word.
data_out_valid  out  1  single-cycle pulse: data_out and the error flags are valid.
parity_err  out  1  parity mismatch in the last frame.
frame_err  out  1  a stop bit was sampled low in the last frame.
break_det  out  1  break detected: all data bits, parity bit (if any) and stop bit sampled 0.
uart_rx_busy  out  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM = IDLE, counters 0, synchroniser flops = 1.
- enable=0: same values as reset, applied synchronously; the input synchroniser keeps running.
- rx_s is the uart_rx value after the 2-FF synchroniser (2-cycle latency). All decisions use rx_s.
- Bit timer cnt counts 0..BIT_CLKS-1, then wraps to 0 and advances the bit.
  - Samples are taken at cnt = HALF-1, HALF and HALF+1.
  - The bit value is the majority of the 3 samples, decided at cnt = HALF+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- IDLE: rx_s=0 -> START, cnt=0, busy=1 on the next cycle.
- START: majority=1 -> IDLE (false start, busy drops, no flags). Otherwise at the wrap -> DATA with bit index 0.
- DATA: each majority bit is shifted in per LSB_FIRST. At the wrap after bit DATA_BITS-1 -> PARITY if PARITY!=0, else STOP.
- PARITY: the majority bit is compared with the computed parity.
  - Odd: XOR of data and parity bit must be 1.
  - Even: that XOR must be 0.
  - Mismatch sets an internal pe flag. At the wrap -> STOP.
- STOP: each stop bit is evaluated at HALF+1; any 0 sets an internal fe flag.
  - With STOP_BITS=2 the first stop bit wraps into the second.
  - At the HALF+1 decision of the last stop bit, on the next cycle:
    - data_out is updated;
    - data_out_valid=1 for exactly 1 cycle;
    - parity_err=pe, frame_err=fe;
    - break_det = fe AND all data bits 0 AND (parity bit 0 or PARITY=0).
  - Then: break_det=1 -> BRK_WAIT. Otherwise -> IDLE (early return, allowing back-to-back frames with ±half-bit drift).
- BRK_WAIT: busy stays 1; leave to IDLE on the first rx_s=1. No valid pulses are generated while in BRK_WAIT.
- data_out and the error flags hold until the next valid pulse, reset, or enable=0.
- Latency: the valid pulse occurs at 2 (sync) + (1+DATA_BITS+(PARITY?1:0)+STOP_BITS-1)*BIT_CLKS + HALF+2 cycles after the uart_rx falling edge.
- Ignored inputs: uart_rx edges mid-bit, outside the sample window.
- Single-cycle glitches: a glitch inside the 3-sample window is outvoted.
- Reset or enable drop mid-frame: the frame is abandoned with no valid pulse; the receiver restarts in IDLE and waits for the next falling edge.

Test Plan:
1. Defaults (BIT_CLKS=2500, HALF=1250), 8N1, send 0xA5 -> one valid pulse 23754 cycles after the falling edge (±1), data_out=0xA5, all error flags 0, busy then 0.
2. 1000-cycle low pulse on an idle line -> no valid pulse; busy high for about 1252 cycles, then 0.
3. DATA_BITS=7, PARITY=2:
   - send 0x41 with parity bit 0 -> data_out=0x41, parity_err=0;
   - repeat with parity bit 1 -> parity_err=1, data_out=0x41.
4. 8N1, send 0x3C with a low stop bit -> frame_err=1, break_det=0, data_out=0x3C. Then a correct 0x55 frame -> frame_err=0, data_out=0x55.
5. Hold uart_rx low for 40000 cycles, then high:
   - exactly one valid pulse, with data_out=0x00, frame_err=1, break_det=1;
   - no further pulse while low;
   - the next valid frame 0x12 is received correctly.
6. Robustness:
   - 1-cycle high glitch at cnt=HALF of data bit 3 in a 0x00 frame -> data_out=0x00.
   - Separately, enable=0 (and separately rst=0) during data bit 4 -> no valid pulse, outputs 0. The following 0x96 frame is received correctly.
   - Two back-to-back 0xFF frames with STOP_BITS=2 -> two valid pulses, no errors.
